// File: rtl/bitstream_decoder.sv
// Stochastic-to-binary converter: counts ones on NUM_CH bitstreams over a
// WINDOW-cycle window and presents each count (unipolar or bipolar) via valid/ready.
module bitstream_decoder #(
  parameter int WINDOW  = 512,
  parameter int NUM_CH  = 4,
  parameter int BIPOLAR = 0
) (
  input  logic                                      clk,
  input  logic                                      n_rst,
  input  logic                                      start,
  input  logic [NUM_CH-1:0]                         bits,
  output logic                                      busy,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NUM_CH*($clog2(WINDOW)+2)-1:0]      value
);

  // state | meaning
  // IDLE  | waiting for start, bits ignored
  // ACCUM | sampling one bit per channel per cycle for WINDOW cycles
  // HOLD  | result presented, waiting for out_ready
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CW = $clog2(WINDOW);
  localparam int VW = CW + 2;

  logic [1:0]    state;
  logic [CW-1:0] sample_cnt;
  logic [CW:0]   ones      [NUM_CH];
  logic [CW:0]   ones_next [NUM_CH];
  logic [NUM_CH*VW-1:0] value_next;
  logic          last_sample;

  assign last_sample = (sample_cnt == CW'(WINDOW - 1));

  // ones_next includes the bit taken on this edge so the final sample is counted
  always_comb begin
    value_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ones_next[k] = ones[k] + {{CW{1'b0}}, bits[k]};
      if (BIPOLAR != 0)
        value_next[k*VW +: VW] = ({1'b0, ones_next[k]} << 1) - VW'(WINDOW);
      else
        value_next[k*VW +: VW] = {1'b0, ones_next[k]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      value      <= '0;
      for (int k = 0; k < NUM_CH; k++) ones[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            sample_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) ones[k] <= '0;
          end
        end
        ACCUM: begin
          sample_cnt <= sample_cnt + 1'b1;
          for (int k = 0; k < NUM_CH; k++) ones[k] <= ones_next[k];
          if (last_sample) begin
            value <= value_next;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (start) begin
              state      <= ACCUM;
              sample_cnt <= '0;
              for (int k = 0; k < NUM_CH; k++) ones[k] <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == ACCUM);
  assign out_valid = (state == HOLD);

endmodule
